// File: rtl/multi_player_clock_pkg.sv
// Shared types, widths and time helpers for the multi-player chess clock.
package multi_player_clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam int TW = 13;
    localparam logic [TW-1:0] MAX_SECONDS = 13'd5999;

    typedef struct packed {
        logic [6:0] minutes;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } digits_t;

    function automatic logic [TW-1:0] init_seconds(input int minutes, input int seconds);
        return TW'(minutes * 60 + seconds);
    endfunction

    function automatic digits_t to_digits(input logic [TW-1:0] t);
        digits_t d;
        logic [TW-1:0] rem_s;
        rem_s       = t % 13'd60;
        d.minutes   = 7'(t / 13'd60);
        d.sec_tens  = 4'(rem_s / 13'd10);
        d.sec_units = 4'(rem_s % 13'd10);
        return d;
    endfunction

endpackage

// File: rtl/multi_player_clock_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick per timed second.
module tick_prescaler
    import multi_player_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_r;

    assign tick = enable && (count_r == LAST_COUNT);

    // Count register: holds while disabled so a paused partial second survives.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear || tick) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/multi_player_clock.sv
// N-player chess clock: per-player countdown, Fischer increment, pause/resume,
// sticky timeout flags and registered decimal digits for one selected player.
module multi_player_clock
    import multi_player_clock_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int MINUTES       = 5,
    parameter int SECONDS       = 0,
    parameter int INCREMENT_S   = 0,
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           move_done,
    input  logic [$clog2(NUM_PLAYERS)-1:0] display_sel,
    output logic [$clog2(NUM_PLAYERS)-1:0] active_player,
    output logic                           running,
    output logic [NUM_PLAYERS-1:0]         timeout,
    output logic                           game_over,
    output logic [6:0]                     disp_minutes,
    output logic [3:0]                     disp_sec_tens,
    output logic [3:0]                     disp_sec_units
);

    localparam int AW = $clog2(NUM_PLAYERS);
    localparam int SW = TW + 1;
    localparam logic [TW-1:0] INIT        = init_seconds(MINUTES, SECONDS);
    localparam logic [SW-1:0] INC_W       = SW'(INCREMENT_S);
    localparam logic [AW-1:0] LAST_PLAYER = AW'(NUM_PLAYERS - 1);
    localparam digits_t       INIT_DIGITS = to_digits(INIT);

    state_t                 state_r, state_n;
    logic [TW-1:0]          time_r [NUM_PLAYERS];
    logic [AW-1:0]          active_r, active_n;
    logic [NUM_PLAYERS-1:0] timeout_r, timeout_n;
    logic                   running_r, running_n;
    logic                   game_over_r, game_over_n;
    digits_t                digits_r, digits_s;
    logic [AW-1:0]          sel_s;
    logic                   run_s, tick_s, expire_s, move_fire_s, write_en_s;
    logic [TW-1:0]          cur_time_s, dec_time_s, new_time_s;
    logic [SW-1:0]          sum_s;

    assign run_s = (state_r == RUN);

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (run_s),
        .clear  (move_fire_s),
        .tick   (tick_s)
    );

    // Active-player datapath: tick decrement, expiry, then saturating increment.
    always_comb begin
        cur_time_s  = time_r[active_r];
        expire_s    = run_s && tick_s && (cur_time_s <= 13'd1);
        move_fire_s = run_s && move_done && !expire_s;
        write_en_s  = run_s && (tick_s || move_done);
        if (run_s && tick_s && (cur_time_s != 13'd0)) begin
            dec_time_s = cur_time_s - 13'd1;
        end else begin
            dec_time_s = cur_time_s;
        end
        sum_s = {1'b0, dec_time_s} + INC_W;
        if (!move_fire_s) begin
            new_time_s = dec_time_s;
        end else if (sum_s > {1'b0, MAX_SECONDS}) begin
            new_time_s = MAX_SECONDS;
        end else begin
            new_time_s = sum_s[TW-1:0];
        end
        if (state_r == IDLE) begin
            active_n = {AW{1'b0}};
        end else if (move_fire_s) begin
            active_n = (active_r == LAST_PLAYER) ? {AW{1'b0}} : active_r + AW'(1);
        end else begin
            active_n = active_r;
        end
        timeout_n = timeout_r;
        if (expire_s) begin
            timeout_n[active_r] = 1'b1;
        end else begin
            timeout_n = timeout_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state; expiry beats pause, pause beats start.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN: begin
                if (expire_s) begin
                    state_n = OVER;
                end else if (pause) begin
                    state_n = PAUSED;
                end else begin
                    state_n = RUN;
                end
            end
            PAUSED:  state_n = start ? RUN : PAUSED;
            OVER:    state_n = OVER;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they flip with it.
    always_comb begin
        running_n   = 1'b0;
        game_over_n = 1'b0;
        case (state_n)
            RUN:     running_n   = 1'b1;
            OVER:    game_over_n = 1'b1;
            default: begin
                running_n   = 1'b0;
                game_over_n = 1'b0;
            end
        endcase
    end

    // Per-player remaining time; only the active entry is ever written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                time_r[p] <= INIT;
            end
        end else if (write_en_s) begin
            time_r[active_r] <= new_time_s;
        end
    end

    generate
        if (NUM_PLAYERS == (1 << AW)) begin : g_sel_full
            assign sel_s = display_sel;
        end else begin : g_sel_clamp
            assign sel_s = (display_sel <= LAST_PLAYER) ? display_sel : {AW{1'b0}};
        end
    endgenerate

    assign digits_s = to_digits(time_r[sel_s]);

    // Registered status and display outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_r    <= {AW{1'b0}};
            timeout_r   <= {NUM_PLAYERS{1'b0}};
            running_r   <= 1'b0;
            game_over_r <= 1'b0;
            digits_r    <= INIT_DIGITS;
        end else begin
            active_r    <= active_n;
            timeout_r   <= timeout_n;
            running_r   <= running_n;
            game_over_r <= game_over_n;
            digits_r    <= digits_s;
        end
    end

    assign active_player  = active_r;
    assign timeout        = timeout_r;
    assign running        = running_r;
    assign game_over      = game_over_r;
    assign disp_minutes   = digits_r.minutes;
    assign disp_sec_tens  = digits_r.sec_tens;
    assign disp_sec_units = digits_r.sec_units;

endmodule

// File: tb/tb_multi_player_clock.sv
// Directed scoreboard bench: several clock configurations share one stimulus stream.
module tb_multi_player_clock;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, start, pause, move_done, display_sel;
    logic [1:0] display_sel3;

    logic       a_act, b_act, c_act, d_act;
    logic [1:0] e_act;
    logic       a_run, b_run, c_run, d_run, e_run;
    logic [1:0] a_to, b_to, c_to, d_to;
    logic [2:0] e_to;
    logic       a_ov, b_ov, c_ov, d_ov, e_ov;
    logic [6:0] a_min, b_min, c_min, d_min, e_min;
    logic [3:0] a_ten, b_ten, c_ten, d_ten, e_ten;
    logic [3:0] a_uni, b_uni, c_uni, d_uni, e_uni;

    multi_player_clock #(.NUM_PLAYERS(2), .MINUTES(0), .SECONDS(3), .INCREMENT_S(0), .TICKS_PER_SEC(4)) u_a (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .move_done(move_done),
        .display_sel(display_sel), .active_player(a_act), .running(a_run), .timeout(a_to),
        .game_over(a_ov), .disp_minutes(a_min), .disp_sec_tens(a_ten), .disp_sec_units(a_uni));

    multi_player_clock #(.NUM_PLAYERS(2), .MINUTES(1), .SECONDS(0), .INCREMENT_S(5), .TICKS_PER_SEC(4)) u_b (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .move_done(move_done),
        .display_sel(display_sel), .active_player(b_act), .running(b_run), .timeout(b_to),
        .game_over(b_ov), .disp_minutes(b_min), .disp_sec_tens(b_ten), .disp_sec_units(b_uni));

    multi_player_clock #(.NUM_PLAYERS(2), .MINUTES(99), .SECONDS(58), .INCREMENT_S(10), .TICKS_PER_SEC(4)) u_c (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .move_done(move_done),
        .display_sel(display_sel), .active_player(c_act), .running(c_run), .timeout(c_to),
        .game_over(c_ov), .disp_minutes(c_min), .disp_sec_tens(c_ten), .disp_sec_units(c_uni));

    multi_player_clock #(.NUM_PLAYERS(2), .MINUTES(0), .SECONDS(1), .INCREMENT_S(0), .TICKS_PER_SEC(4)) u_d (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .move_done(move_done),
        .display_sel(display_sel), .active_player(d_act), .running(d_run), .timeout(d_to),
        .game_over(d_ov), .disp_minutes(d_min), .disp_sec_tens(d_ten), .disp_sec_units(d_uni));

    multi_player_clock #(.NUM_PLAYERS(3), .MINUTES(0), .SECONDS(10), .INCREMENT_S(0), .TICKS_PER_SEC(4)) u_e (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .move_done(move_done),
        .display_sel(display_sel3), .active_player(e_act), .running(e_run), .timeout(e_to),
        .game_over(e_ov), .disp_minutes(e_min), .disp_sec_tens(e_ten), .disp_sec_units(e_uni));

    string       tag_q [$];
    logic [31:0] exp_q [$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
        end else begin
            tag   = tag_q.pop_front();
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) pass_cnt++;
            else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; move_done = 1'b0;
        display_sel = 1'b0; display_sel3 = 2'd0;
        step(2);
        reset = 1'b0;

        // A: 0:03, plain countdown to timeout
        sb_push("a_rst_running", 32'd0); sb_push("a_rst_over", 32'd0);
        sb_push("a_rst_timeout", 32'd0); sb_push("a_rst_units", 32'd3);
        sb_push("a_rst_active", 32'd0);
        sb_check(32'(a_run)); sb_check(32'(a_ov)); sb_check(32'(a_to));
        sb_check(32'(a_uni)); sb_check(32'(a_act));
        start = 1'b1; sb_push("a_start_running", 32'd1);
        step(1); start = 1'b0;
        sb_check(32'(a_run));
        sb_push("a_first_dec_units", 32'd2);
        step(5); sb_check(32'(a_uni));
        sb_push("a_not_over_yet", 32'd0);
        step(6); sb_check(32'(a_ov));
        sb_push("a_timeout", 32'd1); sb_push("a_game_over", 32'd1); sb_push("a_over_running", 32'd0);
        step(1); sb_check(32'(a_to)); sb_check(32'(a_ov)); sb_check(32'(a_run));
        sb_push("a_zero_min", 32'd0); sb_push("a_zero_tens", 32'd0); sb_push("a_zero_units", 32'd0);
        step(1); sb_check(32'(a_min)); sb_check(32'(a_ten)); sb_check(32'(a_uni));
        display_sel = 1'b1;
        sb_push("a_p1_units", 32'd3); sb_push("a_p1_tens", 32'd0);
        step(1); sb_check(32'(a_uni)); sb_check(32'(a_ten));

        // B: 1:00 with +5 increment, move at cycle 6
        display_sel = 1'b0;
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        step(5); move_done = 1'b1; sb_push("b_active_after_move", 32'd1);
        step(1); move_done = 1'b0;
        sb_check(32'(b_act));
        sb_push("b_p0_min", 32'd1); sb_push("b_p0_tens", 32'd0); sb_push("b_p0_units", 32'd4);
        step(1); sb_check(32'(b_min)); sb_check(32'(b_ten)); sb_check(32'(b_uni));
        display_sel = 1'b1;
        sb_push("b_p1_init_min", 32'd1); sb_push("b_p1_init_units", 32'd0);
        step(1); sb_check(32'(b_min)); sb_check(32'(b_uni));
        sb_push("b_p1_not_early", 32'd1);
        step(2); sb_check(32'(b_min));
        sb_push("b_p1_59_min", 32'd0); sb_push("b_p1_59_tens", 32'd5); sb_push("b_p1_59_units", 32'd9);
        step(1); sb_check(32'(b_min)); sb_check(32'(b_ten)); sb_check(32'(b_uni));

        // B: pause two cycles into a second, hold, resume
        display_sel = 1'b0;
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        step(1); pause = 1'b1; sb_push("b_paused_running", 32'd0);
        step(1); pause = 1'b0;
        sb_check(32'(b_run));
        sb_push("b_hold_min", 32'd1); sb_push("b_hold_units", 32'd0); sb_push("b_hold_running", 32'd0);
        step(20); sb_check(32'(b_min)); sb_check(32'(b_uni)); sb_check(32'(b_run));
        start = 1'b1; sb_push("b_resume_running", 32'd1);
        step(1); start = 1'b0;
        sb_check(32'(b_run));
        sb_push("b_resume_no_dec", 32'd1);
        step(2); sb_check(32'(b_min));
        sb_push("b_resume_dec_min", 32'd0); sb_push("b_resume_dec_units", 32'd9);
        step(1); sb_check(32'(b_min)); sb_check(32'(b_uni));

        // C: increment saturates at 99:59
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        move_done = 1'b1; sb_push("c_active", 32'd1);
        step(1); move_done = 1'b0;
        sb_check(32'(c_act));
        sb_push("c_sat_min", 32'd99); sb_push("c_sat_tens", 32'd5); sb_push("c_sat_units", 32'd9);
        step(1); sb_check(32'(c_min)); sb_check(32'(c_ten)); sb_check(32'(c_uni));

        // D: 0:01 corner cases
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        step(3); move_done = 1'b1;
        sb_push("d_tick_wins_timeout", 32'd1); sb_push("d_tick_wins_active", 32'd0);
        sb_push("d_tick_wins_over", 32'd1); sb_push("d_tick_wins_running", 32'd0);
        step(1); move_done = 1'b0;
        sb_check(32'(d_to)); sb_check(32'(d_act)); sb_check(32'(d_ov)); sb_check(32'(d_run));
        sb_push("d_rst_over", 32'd0); sb_push("d_rst_timeout", 32'd0); sb_push("d_rst_running", 32'd0);
        do_reset();
        sb_check(32'(d_ov)); sb_check(32'(d_to)); sb_check(32'(d_run));
        sb_push("d_rst_p0_units", 32'd1); sb_check(32'(d_uni));
        display_sel = 1'b1; sb_push("d_rst_p1_units", 32'd1);
        step(1); sb_check(32'(d_uni));
        display_sel = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        start = 1'b1; pause = 1'b1;
        sb_push("d_pause_wins_running", 32'd0); sb_push("d_pause_wins_over", 32'd0);
        step(1); start = 1'b0; pause = 1'b0;
        sb_check(32'(d_run)); sb_check(32'(d_ov));
        start = 1'b1; sb_push("d_resume_running", 32'd1);
        step(1); start = 1'b0;
        sb_check(32'(d_run));

        // E: three players rotate, player 2 loses one second
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        move_done = 1'b1; sb_push("e_active_1", 32'd1);
        step(1); move_done = 1'b0; sb_check(32'(e_act));
        step(1);
        move_done = 1'b1; sb_push("e_active_2", 32'd2);
        step(1); move_done = 1'b0; sb_check(32'(e_act));
        step(4);
        move_done = 1'b1; sb_push("e_active_0", 32'd0);
        step(1); move_done = 1'b0; sb_check(32'(e_act));
        display_sel3 = 2'd2;
        sb_push("e_p2_tens", 32'd0); sb_push("e_p2_units", 32'd9); sb_push("e_timeout", 32'd0);
        step(1); sb_check(32'(e_ten)); sb_check(32'(e_uni)); sb_check(32'(e_to));
        display_sel3 = 2'd0;
        sb_push("e_p0_tens", 32'd1); sb_push("e_p0_units", 32'd0);
        step(1); sb_check(32'(e_ten)); sb_check(32'(e_uni));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multi_player_clock.md
# multi_player_clock

Parametrised N-player chess game clock: one countdown per player, only the active player's time runs, and a move-done pulse hands the turn to the next player. It supports a Fischer increment, pause/resume and per-player timeout flags. It sits between the game-control FSM and the seven-segment decoders, and supplies decimal digits for one display-selected player. It replaces the single-channel timer and the separate divided-clock domain: everything runs on the system clock with an internal tick prescaler.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of independent countdowns (2..8)
- MINUTES, 5, initial minutes per player (0..99)
- SECONDS, 0, initial seconds per player (0..59)
- INCREMENT_S, 0, seconds added to a player on completing a move (0..59)
- TICKS_PER_SEC, 50_000_000, system clocks per timed second

Ports:
- clock  in  1  system clock, all logic on its rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  single-cycle pulse: begin game (IDLE) or resume (PAUSED)
- pause  in  1  single-cycle pulse: suspend counting (RUN)
- move_done  in  1  single-cycle pulse: active player ends turn
- display_sel  in  $clog2(NUM_PLAYERS)  player shown on the digit outputs
- active_player  out  $clog2(NUM_PLAYERS)  player whose clock runs
- running  out  1  high in RUN only
- timeout  out  NUM_PLAYERS  bit p set when player p's time expired (sticky)
- game_over  out  1  high in OVER
- disp_minutes  out  7  minutes of selected player, 0..99
- disp_sec_tens  out  4  tens of seconds, 0..5
- disp_sec_units  out  4  units of seconds, 0..9

## Operation
- Remaining time is held per player as total seconds, width TW = 13, with MAX_SECONDS = 5999 (99:59). INIT = MINUTES*60+SECONDS.
- States: IDLE, RUN, PAUSED, OVER.
  - IDLE: start -> RUN with active_player = 0. pause and move_done are ignored.
  - RUN: pause -> PAUSED. start is ignored. If start and pause arrive together, pause wins.
  - PAUSED: start -> RUN. pause and move_done are ignored. The prescaler holds its value, so the partial second is preserved.
  - OVER: all inputs are ignored; only reset leaves this state.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, advancing only in RUN.
  - A tick is the cycle where count == TICKS_PER_SEC-1. The count then wraps to 0.
- On a tick in RUN, the active player's time is decremented by 1. If the pre-decrement value is 1, time becomes 0, timeout[active] is set and the state goes to OVER.
- If the game is started with INIT = 0, the first tick sets timeout[0] and goes to OVER; time stays 0, with no underflow.
- move_done in RUN:
  - Adds INCREMENT_S to the active player, saturating at MAX_SECONDS.
  - active_player becomes (active_player+1) mod NUM_PLAYERS.
  - The prescaler clears to 0.
- If move_done coincides with the expiring tick (pre-value 1), the tick wins: timeout is set, OVER is entered, and there is no increment or switch.
- If move_done coincides with a non-expiring tick, the decrement applies first and then the increment: net value is t-1+INCREMENT_S, saturated.
- Display: the selected player's seconds are converted to minutes = t/60, tens = (t%60)/10, units = t%10.

## Timing
- Reset values:
  - state IDLE, all players = INIT, active_player 0, prescaler 0
  - running 0, game_over 0, timeout all 0
  - disp_* = MINUTES, SECONDS/10, SECONDS%10
- All outputs are registered.
- running, game_over, active_player and timeout update on the clock edge that changes the state or time.
- Digit outputs lag the stored time by exactly 1 cycle. A display_sel change is visible 1 cycle later.
- First decrement: TICKS_PER_SEC cycles after start is sampled.
- Reset asserted mid-game restores all reset values on the next edge, regardless of state.

## Structure
- Package multi_player_clock_pkg holds:
  - the state enum (IDLE/RUN/PAUSED/OVER)
  - TW = 13, MAX_SECONDS = 5999
  - a function computing INIT from MINUTES/SECONDS
- Sub-module tick_prescaler:
  - parameter TICKS_PER_SEC
  - inputs clock, reset, enable, clear
  - output tick
- Time storage is an array of NUM_PLAYERS TW-bit registers. Only the active entry is written per cycle.
- Seven-segment encoding stays in the existing decoder, instantiated by the parent.

## Test plan
All scenarios use TICKS_PER_SEC=4 and NUM_PLAYERS=2 unless stated.
- MINUTES=0, SECONDS=3, INCREMENT_S=0: start, no moves. Decrements every 4 cycles: 3->2->1->0. timeout=2'b01 and game_over=1 on the 12th cycle after start; digits read 0,0,0 one cycle later; player 1 still shows 0:03.
- MINUTES=1, SECONDS=0, INCREMENT_S=5: start, move_done at cycle 6.
  - Player 0 is at 59, becomes 64 (1:04); active_player=1; prescaler cleared.
  - Player 1 first reaches 59 four cycles after the move.
- Pause 2 cycles into a second, hold 20 cycles, then start: the next decrement occurs exactly 2 cycles after resume; time is unchanged during the pause.
- Saturation: MINUTES=99, SECONDS=58, INCREMENT_S=10; move_done immediately after start -> player 0 reads 5999 (99:59).
- Corner cases with SECONDS=1:
  - move_done on the expiring tick -> timeout=2'b01 and active_player stays 0.
  - start and pause in the same RUN cycle -> PAUSED.
  - reset during OVER -> IDLE with both players at INIT.
- NUM_PLAYERS=3: three move_done pulses -> active_player sequence 1,2,0; display_sel=2 shows player 2's time after 1 cycle.
